// File: rtl/dp_pkg.sv
// Shared definitions for the rv_datapath codebase slice.
//   alu_op_e : ALU operation encodings carried on the alu_op control port
//   shift_e  : B-path shifter modes carried on the shift control port
//   vsel_e   : writeback source selection carried on the vsel control port
//   OPC_*    : opcode values (instr[6:0]) that select an immediate format
//   FLAG_*   : bit positions of the flags inside status_out {Z,N,C,V}
package dp_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_SLTU  = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SLL  = 2'b01,
    SH_SRL  = 2'b10,
    SH_SRA  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VSEL_C     = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM   = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_e;

  localparam logic [6:0] OPC_LW  = 7'b0100000;
  localparam logic [6:0] OPC_SW  = 7'b1000000;
  localparam logic [6:0] OPC_BEQ = 7'b1100000;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: decodes the immediate of the current instruction and
// sign-extends it to XLEN. Purely combinational.
//   instr [31:0]     in   current instruction
//   imm   [XLEN-1:0] out  sign-extended immediate (0 for unrecognised opcodes)
module imm_gen
  import dp_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  // instr[19:12] never contributes to any supported immediate format.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[19:12];

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LW:  imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_SW:  imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      // Branch offsets are halfword aligned, so bit 0 is always zero.
      OPC_BEQ: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_datapath.sv
// Parametrised multi-cycle integer datapath driven cycle-by-cycle by the
// control FSM: 2R/1W register file (x0 reads zero), A/B operand latches,
// B-path shifter, ALU, result latch C and a {Z,N,C,V} status register.
// Ports:
//   clk, reset (synchronous, active-high)
//   instr, mdata, pc             data sources (immediate, memory, PC)
//   writenum, readnum_a/_b, write  register file addressing / write enable
//   loada, loadb, loadc, loads   capture enables for A, B, C and status
//   asel, bsel, vsel             ALU operand and writeback source selects
//   alu_op, shift, shift_ctrl    ALU operation, shifter mode and override
//   datapath_out                 register C
//   status_out                   {Z,N,C,V}
// Build option: define DP_BYPASS_EN to forward a same-cycle writeback into A/B
// when the written register is also being loaded.
module rv_datapath
  import dp_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] mdata,
  input  logic [XLEN-1:0] pc,
  input  logic [RW-1:0]   writenum,
  input  logic [RW-1:0]   readnum_a,
  input  logic [RW-1:0]   readnum_b,
  input  logic            write,
  input  logic            loada,
  input  logic            loadb,
  input  logic            loadc,
  input  logic            loads,
  input  logic            asel,
  input  logic            bsel,
  input  logic [1:0]      vsel,
  input  logic [2:0]      alu_op,
  input  logic [1:0]      shift,
  input  logic            shift_ctrl,
  output logic [XLEN-1:0] datapath_out,
  output logic [3:0]      status_out
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] reg_a, reg_b, reg_c;
  logic [3:0]      status;
  logic [XLEN-1:0] imm, wb_value, rd_a, rd_b, a_next, b_next;
  logic [XLEN-1:0] b_shift, alu_a, alu_b, result;
  logic [XLEN:0]   sum, diff;
  logic [3:0]      flags;
  logic            wr_en;
  shift_e          sh_mode;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  assign wr_en = write && (writenum != '0);

  always_comb begin
    wb_value = reg_c;
    case (vsel_e'(vsel))
      VSEL_C:     wb_value = reg_c;
      VSEL_PC:    wb_value = pc;
      VSEL_IMM:   wb_value = imm;
      VSEL_MDATA: wb_value = mdata;
      default:    wb_value = reg_c;
    endcase
  end

  // x0 is forced to zero on read so it never depends on array contents.
  assign rd_a = (readnum_a == '0) ? '0 : regs[readnum_a];
  assign rd_b = (readnum_b == '0) ? '0 : regs[readnum_b];

`ifdef DP_BYPASS_EN
  // Forward the value being written this cycle so A/B see it immediately.
  assign a_next = (wr_en && (writenum == readnum_a)) ? wb_value : rd_a;
  assign b_next = (wr_en && (writenum == readnum_b)) ? wb_value : rd_b;
`else
  assign a_next = rd_a;
  assign b_next = rd_b;
`endif

  // Register file: writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[writenum] <= wb_value;
    end
  end

  // shift_ctrl pins the shifter to pass-through for the store address path.
  always_comb begin
    sh_mode = shift_ctrl ? SH_NONE : shift_e'(shift);
    b_shift = reg_b;
    case (sh_mode)
      SH_SLL:  b_shift = reg_b << imm[SW-1:0];
      SH_SRL:  b_shift = reg_b >> imm[SW-1:0];
      SH_SRA:  b_shift = $signed(reg_b) >>> imm[SW-1:0];
      default: b_shift = reg_b;
    endcase
  end

  assign alu_a = asel ? '0 : reg_a;
  assign alu_b = bsel ? imm : b_shift;

  // Subtraction as A + ~B + 1 so the carry-out is directly the not-borrow.
  assign sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff = {1'b0, alu_a} + {1'b0, ~alu_b} + {{XLEN{1'b0}}, 1'b1};

  always_comb begin
    result = sum[XLEN-1:0];
    flags  = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin
        result        = sum[XLEN-1:0];
        flags[FLAG_C] = sum[XLEN];
        flags[FLAG_V] = (alu_a[XLEN-1] == alu_b[XLEN-1]) &&
                        (result[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_SUB: begin
        result        = diff[XLEN-1:0];
        flags[FLAG_C] = diff[XLEN];
        flags[FLAG_V] = (alu_a[XLEN-1] != alu_b[XLEN-1]) &&
                        (result[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_AND:   result = alu_a & alu_b;
      ALU_OR:    result = alu_a | alu_b;
      ALU_XOR:   result = alu_a ^ alu_b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_PASSB: result = alu_b;
      default:   result = sum[XLEN-1:0];
    endcase
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[XLEN-1];
  end

  // Operand, result and status latches; reset wins over every enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_c  <= '0;
      status <= '0;
    end else begin
      if (loada) reg_a  <= a_next;
      if (loadb) reg_b  <= b_next;
      if (loadc) reg_c  <= result;
      if (loads) status <= flags;
    end
  end

  assign datapath_out = reg_c;
  assign status_out   = status;

endmodule
